// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: execution-pipe result payloads,
// the register-file write bundle and source/priority encodings.
package wb_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int NUM_SRC = 4;

  // Pipe IDs double as arbitration priority: lower ID wins.
  typedef enum logic [1:0] {
    EXE_PIPE_ID_ALU = 2'd0,
    EXE_PIPE_ID_LSU = 2'd1,
    EXE_PIPE_ID_MUL = 2'd2,
    EXE_PIPE_ID_DIV = 2'd3
  } exe_pipe_id_e;

  typedef enum logic [NUM_SRC-1:0] {
    WB_SRC_NONE = 4'b0000,
    WB_SRC_ALU  = 4'b0001,
    WB_SRC_LSU  = 4'b0010,
    WB_SRC_MUL  = 4'b0100,
    WB_SRC_DIV  = 4'b1000
  } wb_src_e;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'd0,
    LOAD_LBU = 3'd1,
    LOAD_LH  = 3'd2,
    LOAD_LHU = 3'd3,
    LOAD_LW  = 3'd4
  } load_type_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic              register_write;
    logic [DATA_W-1:0] exe_result;
    logic              do_branch;
    logic [DATA_W-1:0] branch_target;
    logic              icache_invalidate;
  } alu_wb_inf_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic              register_write;
    logic [DATA_W-1:0] load_result;
    load_type_e        load_type;
    logic [1:0]        load_selector;
    logic              unaligned_mem_access;
    logic [DATA_W-1:0] control_flow_pc;
    logic              do_branch;
    logic [DATA_W-1:0] branch_target;
  } lsd_wb_inf_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
  } mul_wb_inf_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
  } div_wb_inf_t;

  typedef struct packed {
    logic              wr_en;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wr_data;
  } wb_ix_inf_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with registered occupancy count; one instance per
// execution pipe in the writeback arbiter.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from ALU/LSU/MUL/DIV, retires one per
// cycle in fixed priority, formats loads and emits control pulses.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  input  logic              lsd_valid_i,
  input  logic              mul_valid_i,
  input  logic              div_valid_i,
  input  alu_wb_inf_t       alu_wb_i,
  input  lsd_wb_inf_t       lsd_wb_i,
  input  mul_wb_inf_t       mul_wb_i,
  input  div_wb_inf_t       div_wb_i,
  output logic              alu_ready_o,
  output logic              lsd_ready_o,
  output logic              mul_ready_o,
  output logic              div_ready_o,
  output wb_ix_inf_t        wb_ix_o,
  output logic              redirect_valid_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic              icache_invalidate_o,
  output logic              misaligned_o,
  output logic [DATA_W-1:0] misaligned_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [DATA_W-1:0] fmt_load(load_type_e lt, logic [1:0] sel,
                                                 logic [DATA_W-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {sel, 3'b000});
    h = 16'(d >> {sel[1], 4'b0000});
    case (lt)
      LOAD_LB:  fmt_load = {{(DATA_W-8){b[7]}}, b};
      LOAD_LBU: fmt_load = {{(DATA_W-8){1'b0}}, b};
      LOAD_LH:  fmt_load = {{(DATA_W-16){h[15]}}, h};
      LOAD_LHU: fmt_load = {{(DATA_W-16){1'b0}}, h};
      default:  fmt_load = d;
    endcase
  endfunction

  alu_wb_inf_t        alu_head;
  lsd_wb_inf_t        lsd_head;
  mul_wb_inf_t        mul_head;
  div_wb_inf_t        div_head;
  logic [NUM_SRC-1:0] src_full;
  logic [NUM_SRC-1:0] src_empty;
  logic [NUM_SRC-1:0] src_pop;
  logic [CNT_W-1:0]   src_cnt [NUM_SRC];

  assign alu_ready_o = (src_cnt[EXE_PIPE_ID_ALU] != CNT_W'(FIFO_DEPTH));
  assign lsd_ready_o = (src_cnt[EXE_PIPE_ID_LSU] != CNT_W'(FIFO_DEPTH));
  assign mul_ready_o = (src_cnt[EXE_PIPE_ID_MUL] != CNT_W'(FIFO_DEPTH));
  assign div_ready_o = (src_cnt[EXE_PIPE_ID_DIV] != CNT_W'(FIFO_DEPTH));

  wb_fifo #(.WIDTH($bits(alu_wb_inf_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst),
    .push(alu_valid_i && alu_ready_o), .push_data(alu_wb_i),
    .pop(src_pop[EXE_PIPE_ID_ALU]), .pop_data(alu_head),
    .count(src_cnt[EXE_PIPE_ID_ALU]), .full(src_full[EXE_PIPE_ID_ALU]),
    .empty(src_empty[EXE_PIPE_ID_ALU])
  );

  wb_fifo #(.WIDTH($bits(lsd_wb_inf_t)), .DEPTH(FIFO_DEPTH)) u_lsd_fifo (
    .clk(clk), .rst(rst),
    .push(lsd_valid_i && lsd_ready_o), .push_data(lsd_wb_i),
    .pop(src_pop[EXE_PIPE_ID_LSU]), .pop_data(lsd_head),
    .count(src_cnt[EXE_PIPE_ID_LSU]), .full(src_full[EXE_PIPE_ID_LSU]),
    .empty(src_empty[EXE_PIPE_ID_LSU])
  );

  wb_fifo #(.WIDTH($bits(mul_wb_inf_t)), .DEPTH(FIFO_DEPTH)) u_mul_fifo (
    .clk(clk), .rst(rst),
    .push(mul_valid_i && mul_ready_o), .push_data(mul_wb_i),
    .pop(src_pop[EXE_PIPE_ID_MUL]), .pop_data(mul_head),
    .count(src_cnt[EXE_PIPE_ID_MUL]), .full(src_full[EXE_PIPE_ID_MUL]),
    .empty(src_empty[EXE_PIPE_ID_MUL])
  );

  wb_fifo #(.WIDTH($bits(div_wb_inf_t)), .DEPTH(FIFO_DEPTH)) u_div_fifo (
    .clk(clk), .rst(rst),
    .push(div_valid_i && div_ready_o), .push_data(div_wb_i),
    .pop(src_pop[EXE_PIPE_ID_DIV]), .pop_data(div_head),
    .count(src_cnt[EXE_PIPE_ID_DIV]), .full(src_full[EXE_PIPE_ID_DIV]),
    .empty(src_empty[EXE_PIPE_ID_DIV])
  );

  // ---- p0: arbitrate among FIFO heads and build the write/pulse bundle ----
  wb_src_e           sel_src_p0;
  logic              vld_p0;
  logic              wr_en_p0;
  logic [REG_W-1:0]  rd_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              redir_p0;
  logic [DATA_W-1:0] redir_pc_p0;
  logic              icinv_p0;
  logic              mis_p0;
  logic [DATA_W-1:0] mis_pc_p0;

  always_comb begin
    sel_src_p0 = WB_SRC_NONE;
    if      (!src_empty[EXE_PIPE_ID_ALU]) sel_src_p0 = WB_SRC_ALU;
    else if (!src_empty[EXE_PIPE_ID_LSU]) sel_src_p0 = WB_SRC_LSU;
    else if (!src_empty[EXE_PIPE_ID_MUL]) sel_src_p0 = WB_SRC_MUL;
    else if (!src_empty[EXE_PIPE_ID_DIV]) sel_src_p0 = WB_SRC_DIV;
  end

  // One-hot source bits line up with the pipe IDs, so the grant is the pop.
  assign src_pop = sel_src_p0;
  assign vld_p0  = (sel_src_p0 != WB_SRC_NONE);

  always_comb begin
    wr_en_p0    = 1'b0;
    rd_p0       = '0;
    wr_data_p0  = '0;
    redir_p0    = 1'b0;
    redir_pc_p0 = '0;
    icinv_p0    = 1'b0;
    mis_p0      = 1'b0;
    mis_pc_p0   = '0;
    case (sel_src_p0)
      WB_SRC_ALU: begin
        rd_p0       = alu_head.rd;
        wr_en_p0    = alu_head.register_write && (alu_head.rd != '0);
        wr_data_p0  = alu_head.exe_result;
        redir_p0    = alu_head.do_branch;
        redir_pc_p0 = alu_head.branch_target;
        icinv_p0    = alu_head.icache_invalidate;
      end
      WB_SRC_LSU: begin
        rd_p0       = lsd_head.rd;
        wr_en_p0    = lsd_head.register_write && (lsd_head.rd != '0) &&
                      !lsd_head.unaligned_mem_access;
        wr_data_p0  = fmt_load(lsd_head.load_type, lsd_head.load_selector,
                               lsd_head.load_result);
        redir_p0    = lsd_head.do_branch;
        redir_pc_p0 = lsd_head.branch_target;
        mis_p0      = lsd_head.unaligned_mem_access;
        mis_pc_p0   = lsd_head.control_flow_pc;
      end
      WB_SRC_MUL: begin
        rd_p0      = mul_head.rd;
        wr_en_p0   = (mul_head.rd != '0);
        wr_data_p0 = mul_head.result;
      end
      WB_SRC_DIV: begin
        rd_p0      = div_head.rd;
        wr_en_p0   = (div_head.rd != '0);
        wr_data_p0 = div_head.result;
      end
      default: ;
    endcase
  end

  // ---- p1: registered outputs; data fields hold when nothing retires ----
  wb_ix_inf_t        wb_ix_p1;
  logic              redir_vld_p1;
  logic [DATA_W-1:0] redir_pc_p1;
  logic              icinv_p1;
  logic              mis_p1;
  logic [DATA_W-1:0] mis_pc_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ix_p1     <= '0;
      redir_vld_p1 <= 1'b0;
      redir_pc_p1  <= '0;
      icinv_p1     <= 1'b0;
      mis_p1       <= 1'b0;
      mis_pc_p1    <= '0;
    end else begin
      wb_ix_p1.wr_en <= vld_p0 && wr_en_p0;
      redir_vld_p1   <= vld_p0 && redir_p0;
      icinv_p1       <= vld_p0 && icinv_p0;
      mis_p1         <= vld_p0 && mis_p0;
      if (vld_p0) begin
        wb_ix_p1.rd      <= rd_p0;
        wb_ix_p1.wr_data <= wr_data_p0;
      end
      if (vld_p0 && redir_p0) redir_pc_p1 <= redir_pc_p0;
      if (vld_p0 && mis_p0)   mis_pc_p1   <= mis_pc_p0;
    end
  end

  assign wb_ix_o             = wb_ix_p1;
  assign redirect_valid_o    = redir_vld_p1;
  assign redirect_pc_o       = redir_pc_p1;
  assign icache_invalidate_o = icinv_p1;
  assign misaligned_o        = mis_p1;
  assign misaligned_pc_o     = mis_pc_p1;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo_chk
    a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
      src_full[i] == (src_cnt[i] == CNT_W'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid, lsd_valid, mul_valid, div_valid;
  alu_wb_inf_t       alu_wb;
  lsd_wb_inf_t       lsd_wb;
  mul_wb_inf_t       mul_wb;
  div_wb_inf_t       div_wb;
  logic              alu_ready, lsd_ready, mul_ready, div_ready;
  wb_ix_inf_t        wb_ix;
  logic              redirect_valid, icache_invalidate, misaligned;
  logic [DATA_W-1:0] redirect_pc, misaligned_pc;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid), .lsd_valid_i(lsd_valid),
    .mul_valid_i(mul_valid), .div_valid_i(div_valid),
    .alu_wb_i(alu_wb), .lsd_wb_i(lsd_wb), .mul_wb_i(mul_wb), .div_wb_i(div_wb),
    .alu_ready_o(alu_ready), .lsd_ready_o(lsd_ready),
    .mul_ready_o(mul_ready), .div_ready_o(div_ready),
    .wb_ix_o(wb_ix),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .icache_invalidate_o(icache_invalidate),
    .misaligned_o(misaligned), .misaligned_pc_o(misaligned_pc)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted push is turned straight into the effect it
  // must have when it retires; retirement takes the first non-empty queue.
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        ic;
    logic        mis;
    logic [31:0] mpc;
  } res_t;

  res_t q_alu[$], q_lsd[$], q_mul[$], q_div[$];
  logic        m_we, m_br, m_ic, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_tgt, m_mpc;

  function automatic logic [31:0] load_value(load_type_e lt, int s, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w / (32'd1 << (8 * s))) % 256);
    h = 16'((w / (32'd1 << (16 * (s / 2)))) % 65536);
    case (lt)
      LOAD_LB:  return (b >= 8'h80) ? 32'(b) - 32'd256 : 32'(b);
      LOAD_LBU: return 32'(b);
      LOAD_LH:  return (h >= 16'h8000) ? 32'(h) - 32'd65536 : 32'(h);
      LOAD_LHU: return 32'(h);
      default:  return w;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    res_t r;
    bit got, ra, rl, rm, rv;
    if (rst) begin
      q_alu.delete(); q_lsd.delete(); q_mul.delete(); q_div.delete();
      m_we = 0; m_br = 0; m_ic = 0; m_mis = 0;
      m_rd = '0; m_data = '0; m_tgt = '0; m_mpc = '0;
    end else begin
      ra = q_alu.size() < DEPTH; rl = q_lsd.size() < DEPTH;
      rm = q_mul.size() < DEPTH; rv = q_div.size() < DEPTH;
      got = 1'b1;
      if      (q_alu.size() != 0) r = q_alu.pop_front();
      else if (q_lsd.size() != 0) r = q_lsd.pop_front();
      else if (q_mul.size() != 0) r = q_mul.pop_front();
      else if (q_div.size() != 0) r = q_div.pop_front();
      else got = 1'b0;
      m_we  = got && r.we;
      m_br  = got && r.br;
      m_ic  = got && r.ic;
      m_mis = got && r.mis;
      if (got) begin m_rd = r.rd; m_data = r.data; end
      if (m_br)  m_tgt = r.tgt;
      if (m_mis) m_mpc = r.mpc;
      if (alu_valid && ra) begin
        r = '{we: alu_wb.register_write && alu_wb.rd != 0, rd: alu_wb.rd,
              data: alu_wb.exe_result, br: alu_wb.do_branch, tgt: alu_wb.branch_target,
              ic: alu_wb.icache_invalidate, mis: 1'b0, mpc: 32'd0};
        q_alu.push_back(r);
      end
      if (lsd_valid && rl) begin
        r = '{we: lsd_wb.register_write && lsd_wb.rd != 0 && !lsd_wb.unaligned_mem_access,
              rd: lsd_wb.rd,
              data: load_value(lsd_wb.load_type, int'(lsd_wb.load_selector), lsd_wb.load_result),
              br: lsd_wb.do_branch, tgt: lsd_wb.branch_target, ic: 1'b0,
              mis: lsd_wb.unaligned_mem_access, mpc: lsd_wb.control_flow_pc};
        q_lsd.push_back(r);
      end
      if (mul_valid && rm) begin
        r = '{we: mul_wb.rd != 0, rd: mul_wb.rd, data: mul_wb.result,
              br: 1'b0, tgt: 32'd0, ic: 1'b0, mis: 1'b0, mpc: 32'd0};
        q_mul.push_back(r);
      end
      if (div_valid && rv) begin
        r = '{we: div_wb.rd != 0, rd: div_wb.rd, data: div_wb.result,
              br: 1'b0, tgt: 32'd0, ic: 1'b0, mis: 1'b0, mpc: 32'd0};
        q_div.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_wr_en", wb_ix.wr_en, m_we);
      if (m_we) begin
        chk("model_rd", wb_ix.rd, m_rd);
        chk("model_wr_data", wb_ix.wr_data, m_data);
      end
      chk("model_redirect", redirect_valid, m_br);
      if (m_br) chk("model_redirect_pc", redirect_pc, m_tgt);
      chk("model_icinv", icache_invalidate, m_ic);
      chk("model_misaligned", misaligned, m_mis);
      if (m_mis) chk("model_misaligned_pc", misaligned_pc, m_mpc);
      chk("model_alu_ready", alu_ready, q_alu.size() < DEPTH);
      chk("model_lsd_ready", lsd_ready, q_lsd.size() < DEPTH);
      chk("model_mul_ready", mul_ready, q_mul.size() < DEPTH);
      chk("model_div_ready", div_ready, q_div.size() < DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsd_valid = 0; mul_valid = 0; div_valid = 0;
    alu_wb = '0; lsd_wb = '0; mul_wb = '0; div_wb = '0;
  endtask

  task automatic do_load(string name, load_type_e lt, logic [1:0] s, logic [31:0] exp);
    idle();
    lsd_valid = 1;
    lsd_wb.rd = 5'd7; lsd_wb.register_write = 1;
    lsd_wb.load_result = 32'h80FF7F01;
    lsd_wb.load_type = lt; lsd_wb.load_selector = s;
    tick();
    idle();
    tick();
    chk({name, "_wr_en"}, wb_ix.wr_en, 1);
    chk(name, wb_ix.wr_data, exp);
  endtask

  initial begin
    idle();
    repeat (3) tick();
    chk("reset_wb_ix", 64'(wb_ix), 0);
    chk("reset_ready", {alu_ready, lsd_ready, mul_ready, div_ready}, 4'hF);
    chk("reset_pulses", {redirect_valid, icache_invalidate, misaligned}, 0);
    rst = 0;
    chk_en = 1;
    tick();

    // Single ALU push: two-cycle latency, one-cycle write
    alu_valid = 1; alu_wb.rd = 5'd5; alu_wb.exe_result = 32'h1234; alu_wb.register_write = 1;
    tick();
    idle();
    chk("alu_lat1_wr_en", wb_ix.wr_en, 0);
    tick();
    chk("alu_lat2_wb", 64'(wb_ix), 64'({1'b1, 5'd5, 32'h1234}));
    tick();
    chk("alu_after_wr_en", wb_ix.wr_en, 0);

    // All four sources push together; retire in priority order
    alu_valid = 1; alu_wb.rd = 5'd1; alu_wb.register_write = 1; alu_wb.exe_result = 32'hA1;
    lsd_valid = 1; lsd_wb.rd = 5'd2; lsd_wb.register_write = 1; lsd_wb.load_type = LOAD_LW;
    lsd_wb.load_result = 32'hB2;
    mul_valid = 1; mul_wb.rd = 5'd3; mul_wb.result = 32'hC3;
    div_valid = 1; div_wb.rd = 5'd4; div_wb.result = 32'hD4;
    tick();
    idle();
    chk("all4_ready_kept", {alu_ready, lsd_ready, mul_ready, div_ready}, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("all4_order_rd", wb_ix.rd, 5'(k));
    end
    tick();
    chk("all4_drained", wb_ix.wr_en, 0);

    // DIV held valid while ALU streams: DIV fills and stalls until ALU stops
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1; alu_wb.rd = 5'd6; alu_wb.register_write = 1; alu_wb.exe_result = 32'(k);
      div_valid = 1; div_wb.rd = 5'd10; div_wb.result = 32'hD0 + 32'(k);
      if (k >= 3) chk("stream_div_stalled", div_ready, 0);
      tick();
    end
    idle();
    tick();
    chk("stream_last_alu", wb_ix.wr_data, 32'd5);
    tick();
    chk("stream_div0", 64'(wb_ix), 64'({1'b1, 5'd10, 32'hD0}));
    chk("stream_div_ready_back", div_ready, 1);
    tick();
    chk("stream_div1", wb_ix.wr_data, 32'hD1);
    tick();

    // Load formatting
    do_load("load_lb_s3",  LOAD_LB,  2'd3, 32'hFFFFFF80);
    do_load("load_lbu_s1", LOAD_LBU, 2'd1, 32'h0000007F);
    do_load("load_lh_s2",  LOAD_LH,  2'd2, 32'hFFFF80FF);
    do_load("load_lhu_s0", LOAD_LHU, 2'd0, 32'h00007F01);
    do_load("load_lw",     LOAD_LW,  2'd0, 32'h80FF7F01);
    tick();

    // x0 write suppressed
    alu_valid = 1; alu_wb.rd = 5'd0; alu_wb.register_write = 1; alu_wb.exe_result = 32'h55;
    tick(); idle(); tick();
    chk("x0_no_write", wb_ix.wr_en, 0);

    // Branch redirect pulse
    alu_valid = 1; alu_wb.rd = 5'd3; alu_wb.register_write = 1; alu_wb.do_branch = 1;
    alu_wb.branch_target = 32'h400; alu_wb.exe_result = 32'h99;
    tick(); idle(); tick();
    chk("redirect_pulse", redirect_valid, 1);
    chk("redirect_pc", redirect_pc, 32'h400);
    tick();
    chk("redirect_one_cycle", redirect_valid, 0);

    // I$ invalidate pulse
    alu_valid = 1; alu_wb.icache_invalidate = 1;
    tick(); idle(); tick();
    chk("icinv_pulse", icache_invalidate, 1);
    tick();
    chk("icinv_one_cycle", icache_invalidate, 0);

    // Unaligned LSU access
    lsd_valid = 1; lsd_wb.rd = 5'd8; lsd_wb.register_write = 1; lsd_wb.unaligned_mem_access = 1;
    lsd_wb.control_flow_pc = 32'h88; lsd_wb.load_type = LOAD_LW;
    tick(); idle(); tick();
    chk("misaligned_pulse", misaligned, 1);
    chk("misaligned_pc", misaligned_pc, 32'h88);
    chk("misaligned_no_write", wb_ix.wr_en, 0);
    tick();
    chk("misaligned_one_cycle", misaligned, 0);

    // Reset while ALU/MUL/DIV FIFOs hold entries
    for (int k = 0; k < 2; k++) begin
      alu_valid = 1; alu_wb.rd = 5'd11; alu_wb.register_write = 1; alu_wb.exe_result = 32'hE0 + 32'(k);
      mul_valid = 1; mul_wb.rd = 5'd12; mul_wb.result = 32'hF0 + 32'(k);
      div_valid = 1; div_wb.rd = 5'd13; div_wb.result = 32'hC0 + 32'(k);
      tick();
    end
    idle();
    chk("pre_reset_retiring", wb_ix.wr_en, 1);
    rst = 1;
    #1;
    chk("async_reset_wb_ix", 64'(wb_ix), 0);
    chk("async_reset_ready", {alu_ready, lsd_ready, mul_ready, div_ready}, 4'hF);
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_stale_retire", wb_ix.wr_en, 0);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-stage arbiter that collects results from the four execution pipes (ALU, LSU, MUL, DIV) and retires at most one register write per cycle to the issue stage over the WB→IX interface. Each pipe's result enters a small per-pipe FIFO. A fixed-priority arbiter then selects one entry per cycle, in the order given by the EXE pipe IDs. The block also formats load data (byte/half extraction and extension), suppresses writes to x0, and emits branch-redirect, I$-invalidate and misaligned-access pulses.

## Interface
Parameters:
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid_i / lsd_valid_i / mul_valid_i / div_valid_i  in  1 each  source result valid.
- alu_wb_i  in  alu_wb_inf_t  ALU result.
- lsd_wb_i  in  lsd_wb_inf_t  LSU result.
- mul_wb_i  in  mul_wb_inf_t  MUL result.
- div_wb_i  in  div_wb_inf_t  DIV result.
- alu_ready_o / lsd_ready_o / mul_ready_o / div_ready_o  out  1 each  source FIFO not full.
- wb_ix_o  out  wb_ix_inf_t  registered register-file write.
- redirect_valid_o  out  1  one-cycle branch redirect pulse.
- redirect_pc_o  out  32  branch target.
- icache_invalidate_o  out  1  one-cycle pulse.
- misaligned_o  out  1  one-cycle pulse for an unaligned LSU access.
- misaligned_pc_o  out  32  control_flow_pc of the offending access.

## Operation
- Push: source X writes its FIFO when valid_X && ready_X. ready_X = (count_X != FIFO_DEPTH), derived from registered count only.
- Push to a full FIFO does not occur. There is no pass-through when full.
- Arbitration: each cycle, pop the head of the highest-priority non-empty FIFO. Priority order is ALU > LSU > MUL > DIV.
- Fixed priority may starve lower pipes. The issue stage guarantees bubbles, so no aging logic.
- Popped entry maps to registered outputs as follows:
  - ALU: wr_en = register_write && rd!=0; wr_data = exe_result.
  - ALU with do_branch: redirect_valid_o=1, redirect_pc_o=branch_target.
  - ALU with icache_invalidate: icache_invalidate_o=1.
  - LSU: wr_en = register_write && rd!=0 && !unaligned_mem_access.
  - LSU with unaligned_mem_access: misaligned_o=1, misaligned_pc_o=control_flow_pc.
  - LSU with do_branch: redirect as for ALU.
  - MUL/DIV: wr_en = rd!=0; wr_data = result.
- Load formatting, with s = load_selector:
  - LB: sign-extend load_result[8s+7:8s].
  - LBU: zero-extend the same byte.
  - LH: sign-extend load_result[16·s[1]+15:16·s[1]].
  - LHU: zero-extend the same halfword.
  - LW: load_result unchanged.
- No pop in a cycle ⇒ next-cycle wr_en, redirect_valid_o, icache_invalidate_o, misaligned_o all 0. Data fields hold their previous values.
- FIFO count, pointers: width clog2(FIFO_DEPTH)+1 and clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave the count unchanged.

## Timing
- Reset (async assert, sync-deassert handled upstream): all counts/pointers 0; all ready_o 1.
- Reset values of outputs: wb_ix_o all-zero; all pulse outputs 0; redirect_pc_o and misaligned_pc_o 0.
- Reset mid-operation discards all FIFO contents with no retirement.
- Latency: a push accepted in cycle N is visible at the FIFO head in N+1. If it wins arbitration in N+1, it appears on outputs in N+2. Minimum latency is 2 cycles.
- Throughput: one retirement per cycle.
- Simultaneous pushes from all four sources in one cycle are legal. They retire in priority order over 4 consecutive cycles.
- ready_X deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop from a full FIFO.
- Pulse outputs are high for exactly one cycle per popped entry.

## Structure
- Add to the defines package: wb_src_e (one-hot over EXE_PIPE_ID_*), and a packed wb_entry_t union-free struct holding the widest source payload plus a source tag. Either add both, or use one FIFO instance per source typed with its own interface struct.
- Sub-module: wb_fifo, a parameterised (payload width, depth) synchronous FIFO with count, full and empty outputs. It is instantiated four times.
- Arbiter, load formatter and output registers live in wb_arbiter.

## Test plan
- Reset, then single ALU push (rd=5, exe_result=0x1234, register_write=1) at cycle 3 → wb_ix_o {wr_en=1, rd=5, wr_data=0x1234} in cycle 5 only.
- Same-cycle pushes from all four sources with rd=1,2,3,4 → retirement order rd=1,2,3,4 in 4 consecutive cycles. No ready_o drops (FIFO_DEPTH=2).
- Hold DIV valid continuously while ALU streams: ALU pushes every cycle; DIV pushes fill its FIFO (2 entries). Then div_ready_o=0 until ALU stops, after which the DIV entries retire.
- LSU loads with load_result=0x80FF7F01:
  - LB, s=3 → 0xFFFFFF80.
  - LBU, s=1 → 0x0000007F.
  - LH, s=2 → 0xFFFF80FF.
  - LHU, s=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Boundary writes and pulses:
  - ALU rd=0, register_write=1 → wr_en=0.
  - ALU do_branch with branch_target=0x400 → redirect_valid_o pulse with redirect_pc_o=0x400.
  - LSU unaligned with pc=0x88 → misaligned_o pulse, misaligned_pc_o=0x88, wr_en=0.
- Assert rst while 3 FIFOs hold entries → outputs zero immediately. After deassertion, no stale entry is retired.
